// File: rtl/key_cmd_encoder.sv
// Debounced 4-key pushbutton front end that turns key presses into a
// valid/ready command stream, plus a free-running periodic tick.
module key_cmd_encoder #(
    parameter int unsigned DB_CYCLES   = 1000000,
    parameter int unsigned TICK_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] KEY,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_code,
    output logic [3:0] key_level,
    output logic       tick,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(DB_CYCLES);
    localparam int unsigned TW = $clog2(TICK_CYCLES);

    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [CW-1:0] db_cnt      [4];
    logic [CW-1:0] db_cnt_next [4];
    logic [3:0]    stable;
    logic [3:0]    level_next;
    logic [3:0]    press;
    logic          multi_press;
    logic [1:0]    win_code;
    logic [TW-1:0] tick_cnt;

    // The stable (active-low) key value is kept only as its inverse in
    // key_level, so key_level stays a plain register output.
    assign stable = ~key_level;

    // Two-flop synchronizer for the raw asynchronous keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    // Per-key debounce: accept the synchronized value after DB_CYCLES
    // consecutive cycles of disagreement with the stable value.
    always_comb begin
        level_next = key_level;
        for (int unsigned i = 0; i < 4; i++) begin
            db_cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (db_cnt[i] == CW'(DB_CYCLES - 1)) begin
                    level_next[i] = ~sync2[i];
                end else begin
                    db_cnt_next[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press detection and highest-index-wins selection.
    always_comb begin
        press       = level_next & ~key_level;
        multi_press = (press & (press - 4'd1)) != '0;
        win_code    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (press[i]) begin
                win_code = 2'(i);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_level <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_level <= level_next;
            for (int unsigned i = 0; i < 4; i++) begin
                db_cnt[i] <= db_cnt_next[i];
            end
        end
    end

    // Command holding register with valid/ready handshake and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (press != '0) begin
                if (!cmd_valid || cmd_ready) begin
                    cmd_valid <= 1'b1;
                    cmd_code  <= win_code;
                end
                if (multi_press || (cmd_valid && !cmd_ready)) begin
                    overrun <= 1'b1;
                end
            end else if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end
        end
    end

    // Free-running tick counter; tick is registered so it is high while
    // the counter sits at TICK_CYCLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            if (tick_cnt == TW'(TICK_CYCLES - 1)) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            tick <= (tick_cnt == TW'(TICK_CYCLES - 2));
        end
    end

endmodule

// File: doc/key_cmd_encoder.md
KEY_CMD_ENCODER -- requirements
Module: key_cmd_encoder

Interface
REQ-001 Parameter DB_CYCLES, default 1000000: debounce stability window in clk cycles (20 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter TICK_CYCLES, default 50000000: period of the tick output in clk cycles (1 s at 50 MHz); legal range >= 2.
REQ-003 Port clk  input  1: single clock; all state SHALL be clocked on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port KEY  input  4: raw pushbuttons, asynchronous to clk, active-low (0 = pressed).
REQ-006 Port cmd_valid  output  1: a command is held on cmd_code.
REQ-007 Port cmd_ready  input  1: the consumer accepts the command when cmd_valid and cmd_ready are both 1 at a rising edge.
REQ-008 Port cmd_code  output  2: 3 = shift forward (KEY[3]), 2 = all on (KEY[2]), 1 = all off (KEY[1]), 0 = shift reverse (KEY[0]).
REQ-009 Port key_level  output  4: debounced key state, active-high (1 = pressed).
REQ-010 Port tick  output  1: one-cycle pulse every TICK_CYCLES cycles.
REQ-011 Port overrun  output  1: sticky flag, set when a press event is dropped.

Function
REQ-012 Each KEY bit SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-013 Each key SHALL have its own debounce counter, ceil(log2(DB_CYCLES)) bits wide, that clears whenever the synchronized value equals the stable value.
REQ-014 When the synchronized value has differed from the stable value for DB_CYCLES consecutive cycles, the stable value SHALL take the synchronized value and the counter SHALL clear on the same edge.
REQ-015 A glitch shorter than DB_CYCLES cycles SHALL leave the stable value and key_level unchanged.
REQ-016 key_level[i] SHALL equal the inverted stable value of KEY[i]. Latency from a stable raw change to key_level change SHALL be 2 + DB_CYCLES cycles.
REQ-017 A press event SHALL occur when key_level[i] goes from 0 to 1. A release SHALL produce no command.
REQ-018 cmd_valid SHALL rise, and cmd_code SHALL load, on the same edge on which key_level rises.
REQ-019 If several press events occur in one cycle, the highest index SHALL win and the others SHALL be dropped.
REQ-020 While cmd_valid=1 and cmd_ready=0, cmd_code SHALL hold; a new press event SHALL be dropped.
REQ-021 When cmd_valid=1 and cmd_ready=1 with no press event in the same cycle, cmd_valid SHALL drop to 0 on that edge.
REQ-022 When cmd_valid=1, cmd_ready=1 and a press event coincide, the new command SHALL load and cmd_valid SHALL stay 1.
REQ-023 When cmd_valid=0, a press event SHALL load regardless of cmd_ready.
REQ-024 overrun SHALL set on any dropped press event (REQ-019 or REQ-020) and SHALL clear only on reset.
REQ-025 The tick counter SHALL count 0..TICK_CYCLES-1 and wrap to 0.
REQ-026 tick SHALL be 1 exactly in the cycles where the counter equals TICK_CYCLES-1.
REQ-027 The tick counter SHALL be free-running and independent of the keys and of the handshake.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately force all synchronizer flops and stable values to 1 (released), and all debounce counters and the tick counter to 0.
REQ-030 Asserting rst_n=0 SHALL immediately force cmd_valid=0, cmd_code=0, key_level=0, tick=0 and overrun=0.
REQ-031 A reset during an unaccepted command SHALL discard it; no command SHALL appear after release unless a new press completes debounce.
REQ-032 A key held pressed through reset release SHALL produce one press event, 2 + DB_CYCLES cycles after release.

Verification (DB_CYCLES=4, TICK_CYCLES=10)
REQ-033 Bench SHALL check: KEY[2] held low from cycle 0, cmd_ready=1 -> key_level=4'b0100 and cmd_valid=1 with cmd_code=2 at cycle 6; cmd_valid=0 at cycle 7.
REQ-034 Bench SHALL check: KEY[1] low for 3 cycles, then high -> key_level, cmd_valid and overrun remain 0.
REQ-035 Bench SHALL check: KEY[3] and KEY[0] fall together, cmd_ready=0 -> cmd_code=3 and overrun=1.
REQ-036 Bench SHALL check: with cmd_code=3 pending, cmd_ready=0, KEY[1] pressed -> cmd_code stays 3 and overrun=1.
REQ-037 Bench SHALL check: with cmd_code=3 pending, cmd_ready=1 in the same cycle key_level[2] rises -> cmd_code=2, cmd_valid stays 1, overrun unchanged.
REQ-038 Bench SHALL check: with no keys pressed, tick is high at cycles 9, 19 and 29 after reset release; rst_n pulsed low mid-count -> tick and all outputs are 0 immediately, and the next tick comes 10 cycles after release.
